branch_ctrl: RTL and testbench

- Parametrised successor to the combinational jump/branch decoder.
- Holds a runtime-loadable branch-target table and registered ALU condition flags.
- Adds a hardware return-address stack, so the ISA gains CALL/RET.
- Sits between instruction ROM/ALU and the program counter (fetch unit); drives jump_en/Target to the PC each cycle.

---
 rtl/branch_ctrl_pkg.sv | 25 ++
 rtl/branch_ctrl_ret_stack.sv | 56 +++++
 rtl/branch_ctrl.sv | 141 ++++++++++++++
 tb/tb_branch_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared opcode encoding and sizing helpers for the branch controller and its return stack.
package branch_ctrl_pkg;

    localparam int OPW = 4;

    typedef enum logic [OPW-1:0] {
        kNOP  = 4'h0,
        kJ    = 4'h1,
        kBRE  = 4'h2,
        kBRGT = 4'h3,
        kCALL = 4'h4,
        kRET  = 4'h5
    } op_t;

    // Width able to hold a count from 0 to n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width able to index n entries (at least one bit).
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/branch_ctrl_ret_stack.sv
// Return-address LIFO: push/pop qualified by full/empty, never wraps; top reads combinationally.
import branch_ctrl_pkg::*;

module ret_stack #(
    parameter int PW = 16,
    parameter int SD = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          push,
    input  logic          pop,
    input  logic [PW-1:0] din,
    output logic [PW-1:0] top,
    output logic          empty,
    output logic          full
);

    localparam int SPW = cnt_width(SD);
    localparam int AW  = idx_width(SD);

    logic [PW-1:0]  mem [SD];
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_m1;
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  rd_idx;
    logic           do_push;
    logic           do_pop;

    assign empty   = (sp == '0);
    assign full    = (sp == SPW'(SD));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign sp_m1   = sp - SPW'(1);
    assign wr_idx  = sp[AW-1:0];
    assign rd_idx  = sp_m1[AW-1:0];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + SPW'(1);
        end else if (do_pop) begin
            sp <= sp_m1;
        end
    end

    // Entries at or above sp are don't-care, so the storage needs no reset.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

    assign top = empty ? '0 : mem[rd_idx];

endmodule

// File: rtl/branch_ctrl.sv
// Jump/branch/call/return decoder with loadable target table, registered ALU flags and return stack.
import branch_ctrl_pkg::*;

module branch_ctrl #(
    parameter int IW   = 9,
    parameter int PW   = 16,
    parameter int IDXW = 5,
    parameter int SD   = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [IW-1:0]   Instruction,
    input  logic [PW-1:0]   PC,
    input  logic            advance,
    input  logic            ZERO,
    input  logic            GREATER,
    input  logic            flag_we,
    input  logic            tbl_we,
    input  logic [IDXW-1:0] tbl_waddr,
    input  logic [PW-1:0]   tbl_wdata,
    output logic            jump_en,
    output logic [PW-1:0]   Target,
    output logic            stack_ovf,
    output logic            stack_unf
);

    localparam int TD = 2 ** IDXW;

    logic [PW-1:0]   tbl [TD];
    logic            z_q;
    logic            g_q;

    logic [OPW-1:0]  opcode;
    logic [IDXW-1:0] idx;
    logic [PW-1:0]   tbl_rd;

    logic            push;
    logic            pop;
    logic            set_ovf;
    logic            set_unf;
    logic [PW-1:0]   ret_addr;
    logic [PW-1:0]   stk_top;
    logic            stk_empty;
    logic            stk_full;

    assign opcode   = Instruction[IW-1:IW-OPW];
    assign idx      = Instruction[IDXW-1:0];
    assign tbl_rd   = tbl[idx];
    assign ret_addr = PC + PW'(1);

    // Asynchronous read sees the pre-write value when the same index is written this cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < TD; i++) begin
                tbl[i] <= '0;
            end
        end else if (tbl_we) begin
            tbl[tbl_waddr] <= tbl_wdata;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            z_q <= 1'b0;
            g_q <= 1'b0;
        end else if (advance && flag_we) begin
            z_q <= ZERO;
            g_q <= GREATER;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            if (set_ovf) stack_ovf <= 1'b1;
            if (set_unf) stack_unf <= 1'b1;
        end
    end

    always_comb begin
        jump_en = 1'b0;
        Target  = '0;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (!Reset) begin
            case (opcode)
                kJ: begin
                    jump_en = 1'b1;
                    Target  = tbl_rd;
                end
                kBRE: begin
                    jump_en = z_q;
                    Target  = z_q ? tbl_rd : '0;
                end
                kBRGT: begin
                    jump_en = g_q;
                    Target  = g_q ? tbl_rd : '0;
                end
                kCALL: begin
                    // The jump is taken even when the stack is full; only the push is dropped.
                    jump_en = 1'b1;
                    Target  = tbl_rd;
                    push    = advance && !stk_full;
                    set_ovf = advance && stk_full;
                end
                kRET: begin
                    if (!stk_empty) begin
                        jump_en = 1'b1;
                        Target  = stk_top;
                        pop     = advance;
                    end else begin
                        set_unf = advance;
                    end
                end
                default: begin
                    jump_en = 1'b0;
                    Target  = '0;
                end
            endcase
        end
    end

    ret_stack #(
        .PW (PW),
        .SD (SD)
    ) u_ret_stack (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (push),
        .pop   (pop),
        .din   (ret_addr),
        .top   (stk_top),
        .empty (stk_empty),
        .full  (stk_full)
    );

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed walk through the key scenarios followed by randomized traffic, checked against a queue-based model.
module tb_branch_ctrl;

    localparam int IW   = 9;
    localparam int PW   = 16;
    localparam int IDXW = 5;
    localparam int SD   = 4;
    localparam int TD   = 2 ** IDXW;

    localparam logic [3:0] OP_J    = 4'h1;
    localparam logic [3:0] OP_BRE  = 4'h2;
    localparam logic [3:0] OP_BRGT = 4'h3;
    localparam logic [3:0] OP_CALL = 4'h4;
    localparam logic [3:0] OP_RET  = 4'h5;
    localparam logic [3:0] OP_NOP  = 4'h0;

    logic            Clk = 1'b0;
    logic            Reset;
    logic [IW-1:0]   Instruction;
    logic [PW-1:0]   PC;
    logic            advance;
    logic            ZERO;
    logic            GREATER;
    logic            flag_we;
    logic            tbl_we;
    logic [IDXW-1:0] tbl_waddr;
    logic [PW-1:0]   tbl_wdata;
    logic            jump_en;
    logic [PW-1:0]   Target;
    logic            stack_ovf;
    logic            stack_unf;

    branch_ctrl #(.IW(IW), .PW(PW), .IDXW(IDXW), .SD(SD)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Instruction (Instruction),
        .PC          (PC),
        .advance     (advance),
        .ZERO        (ZERO),
        .GREATER     (GREATER),
        .flag_we     (flag_we),
        .tbl_we      (tbl_we),
        .tbl_waddr   (tbl_waddr),
        .tbl_wdata   (tbl_wdata),
        .jump_en     (jump_en),
        .Target      (Target),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [PW-1:0] m_tbl [TD];
    logic          m_z, m_g, m_ovf, m_unf;
    logic [PW-1:0] m_stk [$];

    logic          obs_je;
    logic [PW-1:0] obs_tg;
    logic          obs_ovf, obs_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [3:0] op, input int idx);
        logic [IDXW-1:0] i5;
        i5 = IDXW'(idx);
        return {op, i5};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < TD; i++) m_tbl[i] = '0;
        m_z = 0; m_g = 0; m_ovf = 0; m_unf = 0;
        m_stk.delete();
    endtask

    task automatic step(input logic [IW-1:0] ins, input logic [PW-1:0] pc, input logic adv,
                        input logic fwe, input logic zr, input logic gt,
                        input logic twe, input logic [IDXW-1:0] wa, input logic [PW-1:0] wd);
        logic [3:0]    op;
        int            ix;
        logic          e_je;
        logic [PW-1:0] e_tg;
        Instruction = ins; PC = pc; advance = adv; flag_we = fwe; ZERO = zr; GREATER = gt;
        tbl_we = twe; tbl_waddr = wa; tbl_wdata = wd;
        op = ins[IW-1:IW-4];
        ix = int'(ins[IDXW-1:0]);
        e_je = 0; e_tg = 0;
        if (op == OP_J || op == OP_CALL) begin
            e_je = 1; e_tg = m_tbl[ix];
        end else if (op == OP_BRE && m_z) begin
            e_je = 1; e_tg = m_tbl[ix];
        end else if (op == OP_BRGT && m_g) begin
            e_je = 1; e_tg = m_tbl[ix];
        end else if (op == OP_RET && m_stk.size() > 0) begin
            e_je = 1; e_tg = m_stk[$];
        end
        @(negedge Clk);
        chk("jump_en", 32'(jump_en), 32'(e_je));
        chk("target", 32'(Target), 32'(e_tg));
        chk("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
        chk("stack_unf", 32'(stack_unf), 32'(m_unf));
        obs_je = jump_en; obs_tg = Target; obs_ovf = stack_ovf; obs_unf = stack_unf;
        @(posedge Clk);
        if (twe) m_tbl[int'(wa)] = wd;
        if (adv) begin
            if (fwe) begin m_z = zr; m_g = gt; end
            if (op == OP_CALL) begin
                if (m_stk.size() == SD) m_ovf = 1;
                else m_stk.push_back(pc + 16'd1);
            end else if (op == OP_RET) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_unf = 1;
            end
        end
        #1;
    endtask

    task automatic simple(input logic [IW-1:0] ins, input logic [PW-1:0] pc, input logic adv);
        step(ins, pc, adv, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wr_tbl(input int a, input logic [PW-1:0] d);
        step(mk(OP_NOP, 0), 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, IDXW'(a), d);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        model_reset();
        chk("rst_jump_en", 32'(jump_en), 32'h0);
        chk("rst_target", 32'(Target), 32'h0);
        chk("rst_ovf", 32'(stack_ovf), 32'h0);
        chk("rst_unf", 32'(stack_unf), 32'h0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Instruction = '0; PC = '0; advance = 0; ZERO = 0; GREATER = 0;
        flag_we = 0; tbl_we = 0; tbl_waddr = '0; tbl_wdata = '0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Table loads and same-cycle read/write
        wr_tbl(2, 16'h0452);
        wr_tbl(1, 16'h01F7);
        step(mk(OP_J, 3), 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 16'h0434);
        chk("tbl_old_value", 32'(obs_tg), 32'h0000);
        simple(mk(OP_J, 3), 16'h0, 1'b1);
        chk("tbl_new_value", 32'(obs_tg), 32'h0434);

        // Registered flags
        step(mk(OP_NOP, 0), 16'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        simple(mk(OP_BRE, 2), 16'h6, 1'b1);
        chk("bre_taken", 32'({obs_je, obs_tg}), 32'({1'b1, 16'h0452}));
        simple(mk(OP_BRGT, 2), 16'h7, 1'b1);
        chk("brgt_not_taken", 32'(obs_je), 32'h0);
        step(mk(OP_BRE, 2), 16'h8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        chk("bre_live_ignored", 32'(obs_je), 32'h1);

        // Stalled CALL pushes once
        repeat (3) simple(mk(OP_CALL, 1), 16'h0010, 1'b0);
        simple(mk(OP_CALL, 1), 16'h0010, 1'b1);
        chk("call_target", 32'(obs_tg), 32'h01F7);
        simple(mk(OP_RET, 0), 16'h01F7, 1'b1);
        chk("ret_target", 32'({obs_je, obs_tg}), 32'({1'b1, 16'h0011}));
        simple(mk(OP_RET, 0), 16'h0011, 1'b0);
        chk("ret_empty_after", 32'(obs_je), 32'h0);

        // Overflow / underflow
        for (int i = 0; i < 5; i++) begin
            simple(mk(OP_CALL, 1), 16'h0020 + 16'(i), 1'b1);
            chk("ovf_call_taken", 32'(obs_je), 32'h1);
        end
        for (int i = 0; i < 4; i++) begin
            simple(mk(OP_RET, 0), 16'h0100, 1'b1);
            if (i == 0) chk("ovf_sticky", 32'(obs_ovf), 32'h1);
            chk("ret_seq", 32'(obs_tg), 32'(16'h0024 - 16'(i)));
        end
        simple(mk(OP_RET, 0), 16'h0100, 1'b1);
        chk("unf_ret_not_taken", 32'(obs_je), 32'h0);
        simple(mk(OP_NOP, 0), 16'h0101, 1'b1);
        chk("unf_sticky", 32'(obs_unf), 32'h1);

        // Mid-run reset with a jump presented
        Instruction = mk(OP_J, 3);
        do_reset();
        simple(mk(OP_J, 5), 16'h0, 1'b1);
        chk("post_rst_j5", 32'({obs_je, obs_tg}), 32'({1'b1, 16'h0000}));
        simple(mk(OP_BRE, 5), 16'h0, 1'b1);
        chk("post_rst_flags", 32'(obs_je), 32'h0);

        // Return-address wrap
        simple(mk(OP_CALL, 0), 16'hFFFF, 1'b1);
        simple(mk(OP_RET, 0), 16'h0000, 1'b1);
        chk("wrap_ret", 32'({obs_je, obs_tg}), 32'({1'b1, 16'h0000}));

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            logic [3:0] op;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                op = 4'($urandom_range(0, 7));
                step(mk(op, int'($urandom_range(0, TD - 1))), 16'($urandom),
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                     1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                     IDXW'($urandom), 16'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
